// File: rtl/ysyx_25040111_pkg.sv
// ysyx_25040111_pkg
// Shared definitions for the load/store unit: FSM state encoding, LSU size
// codes, AXI4 burst/response constants and the size-code-to-AxSIZE helper.
// No ports (package).

package ysyx_25040111_pkg;

  // LSU transaction FSM states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_WR   = 3'd3,
    ST_B    = 3'd4
  } lsu_state_e;

  // LSU size codes carried on lsu_rmask / lsu_wmask (2'b11 also means word)
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // AXI4 burst types
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // AXI4 response codes
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // LSU size code to AXI AxSIZE (log2 of bytes per beat)
  function automatic logic [2:0] axi_size(input logic [1:0] mask);
    return {1'b0, (mask == 2'b11) ? SIZE_WORD : mask};
  endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_if.sv
// ysyx_25040111_lsu_if
// AXI4 master bus used by the LSU: AR, R, AW, W and B channels.
//   master modport : LSU side (drives valids on AR/AW/W, readies on R/B)
//   slave modport  : memory/interconnect side
// No ports; instantiate once and connect the LSU via the master modport.

interface ysyx_25040111_lsu_if;

  // AR channel
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  // R channel
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;

  // AW channel
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  // W channel
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  // B channel
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast,
    output rready,
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );

endinterface

// File: rtl/ysyx_25040111_lsu_align.sv
// ysyx_25040111_lsu_align
// Combinational data alignment for the LSU.
//   rd_offset/rd_mask/rd_sign/rd_raw -> rd_data : bus beat shifted down by the
//     byte offset, then byte/half zero- or sign-extended; words pass unshifted.
//   wr_offset/wr_mask/wr_raw -> wr_data/wr_strb : LSB-aligned store data and
//     its byte strobe moved up to the byte offset (truncated to 4 lanes).
// Misaligned halves/words are not split; lanes shifted past bit 31 are lost.

module ysyx_25040111_lsu_align
  import ysyx_25040111_pkg::*;
(
  input  logic [1:0]  rd_offset,
  input  logic [1:0]  rd_mask,
  input  logic        rd_sign,
  input  logic [31:0] rd_raw,
  output logic [31:0] rd_data,
  input  logic [1:0]  wr_offset,
  input  logic [1:0]  wr_mask,
  input  logic [31:0] wr_raw,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb
);

  logic [15:0] rd_shifted;
  logic [3:0]  strb_base;

  always_comb begin
    rd_shifted = 16'(rd_raw >> {rd_offset, 3'b000});
    case (rd_mask)
      SIZE_BYTE: rd_data = {{24{rd_sign & rd_shifted[7]}},  rd_shifted[7:0]};
      SIZE_HALF: rd_data = {{16{rd_sign & rd_shifted[15]}}, rd_shifted};
      default:   rd_data = rd_raw;
    endcase
  end

  always_comb begin
    case (wr_mask)
      SIZE_BYTE: strb_base = 4'b0001;
      SIZE_HALF: strb_base = 4'b0011;
      default:   strb_base = 4'b1111;
    endcase
    wr_data = wr_raw << {wr_offset, 3'b000};
    wr_strb = 4'(strb_base << wr_offset);
  end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// ysyx_25040111_lsu
// Load/store unit bridging a simple valid/ready request port to an AXI4
// master. One transaction is outstanding at a time; reads win over writes
// when both are requested in IDLE.
//
// Ports
//   clock, reset          : system clock, synchronous active-high reset
//   lsu_rvalid/lsu_rready : read request / one pulse per returned beat
//   lsu_raddr, lsu_rlen, lsu_burst, lsu_rmask, lsu_rsign : read fields
//   lsu_rdata             : aligned, extended beat (valid while lsu_rready)
//   lsu_wvalid/lsu_wready : write request / one pulse on completion
//   lsu_waddr, lsu_wdata, lsu_wmask : write fields (data LSB-aligned)
//   lsu_err               : sticky bus-error flag
//   bus                   : AXI4 master (ysyx_25040111_lsu_if.master)
//
// Build option
//   YSYX_25040111_LSU_ERR_EN : when defined, a non-OKAY rresp on any beat or
//   a non-OKAY bresp sets lsu_err until reset; otherwise lsu_err is tied 0.
//
// State | meaning
// IDLE  | waiting for a request; latches fields of the accepted one
// AR    | arvalid high until arready
// R     | rready high; beats passed through until rlast
// WR    | awvalid and wvalid each held until their own handshake
// B     | bready high until bvalid; completion pulses lsu_wready

module ysyx_25040111_lsu
  import ysyx_25040111_pkg::*;
(
  input  logic        clock,
  input  logic        reset,

  input  logic        lsu_rvalid,
  output logic        lsu_rready,
  input  logic [31:0] lsu_raddr,
  input  logic [7:0]  lsu_rlen,
  input  logic        lsu_burst,
  input  logic [1:0]  lsu_rmask,
  input  logic        lsu_rsign,
  output logic [31:0] lsu_rdata,

  input  logic        lsu_wvalid,
  output logic        lsu_wready,
  input  logic [31:0] lsu_waddr,
  input  logic [31:0] lsu_wdata,
  input  logic [1:0]  lsu_wmask,

  output logic        lsu_err,

  ysyx_25040111_lsu_if.master bus
);

  lsu_state_e  state;

  // Fields of the accepted request; address and size are shared by both
  // directions since only one transaction is ever in flight.
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        req_burst;
  logic [1:0]  req_mask;
  logic        req_sign;
  logic [31:0] req_wdata;

  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;

  logic        aw_done;
  logic        w_done;

  // A channel counts as done once its valid has dropped or handshakes now.
  assign aw_done = !awvalid_q || bus.awready;
  assign w_done  = !wvalid_q  || bus.wready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_addr  <= '0;
      req_len   <= '0;
      req_burst <= 1'b0;
      req_mask  <= '0;
      req_sign  <= 1'b0;
      req_wdata <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lsu_rvalid) begin
            req_addr  <= lsu_raddr;
            req_len   <= lsu_rlen;
            req_burst <= lsu_burst;
            req_mask  <= lsu_rmask;
            req_sign  <= lsu_rsign;
            arvalid_q <= 1'b1;
            state     <= ST_AR;
          end else if (lsu_wvalid) begin
            req_addr  <= lsu_waddr;
            req_mask  <= lsu_wmask;
            req_wdata <= lsu_wdata;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= ST_WR;
          end
        end
        ST_AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_R;
          end
        end
        ST_R: begin
          if (bus.rvalid && bus.rlast) begin
            rready_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_WR: begin
          if (bus.awready) awvalid_q <= 1'b0;
          if (bus.wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state    <= ST_B;
          end
        end
        ST_B: begin
          if (bus.bvalid) begin
            bready_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef YSYX_25040111_LSU_ERR_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      lsu_err <= 1'b0;
    end else if ((rready_q && bus.rvalid && (bus.rresp != RESP_OKAY)) ||
                 (bready_q && bus.bvalid && (bus.bresp != RESP_OKAY))) begin
      lsu_err <= 1'b1;
    end
  end
`else
  logic unused_resp;
  assign unused_resp = ^{bus.rresp, bus.bresp};
  assign lsu_err     = 1'b0;
`endif

  // Ready pulses are combinational so the requester sees them on the very
  // handshake edge and can drop its valid before IDLE samples it again.
  assign lsu_rready = rready_q && bus.rvalid;
  assign lsu_wready = bready_q && bus.bvalid;

  assign bus.arvalid = arvalid_q;
  assign bus.araddr  = req_addr;
  assign bus.arlen   = req_len;
  assign bus.arsize  = axi_size(req_mask);
  assign bus.arburst = req_burst ? BURST_INCR : BURST_FIXED;
  assign bus.rready  = rready_q;

  assign bus.awvalid = awvalid_q;
  assign bus.awaddr  = req_addr;
  assign bus.awlen   = 8'd0;
  assign bus.awsize  = axi_size(req_mask);
  assign bus.awburst = BURST_INCR;
  assign bus.wvalid  = wvalid_q;
  assign bus.wlast   = 1'b1;
  assign bus.bready  = bready_q;

  ysyx_25040111_lsu_align u_align (
    .rd_offset (req_addr[1:0]),
    .rd_mask   (req_mask),
    .rd_sign   (req_sign),
    .rd_raw    (bus.rdata),
    .rd_data   (lsu_rdata),
    .wr_offset (req_addr[1:0]),
    .wr_mask   (req_mask),
    .wr_raw    (req_wdata),
    .wr_data   (bus.wdata),
    .wr_strb   (bus.wstrb)
  );

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// tb_ysyx_25040111_lsu
// Self-checking bench: the initial block plays requester and AXI slave with
// randomized delays/data; a negedge compare process checks every meaningful
// DUT output against a byte-level behavioural model.
`timescale 1ns/1ps

module tb_ysyx_25040111_lsu;

`ifdef YSYX_25040111_LSU_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  always #5 clock = ~clock;

  logic        lsu_rvalid, lsu_rready, lsu_burst, lsu_rsign;
  logic [31:0] lsu_raddr, lsu_rdata;
  logic [7:0]  lsu_rlen;
  logic [1:0]  lsu_rmask;
  logic        lsu_wvalid, lsu_wready, lsu_err;
  logic [31:0] lsu_waddr, lsu_wdata;
  logic [1:0]  lsu_wmask;

  ysyx_25040111_lsu_if bus ();

  ysyx_25040111_lsu dut (
    .clock      (clock),
    .reset      (reset),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rready (lsu_rready),
    .lsu_raddr  (lsu_raddr),
    .lsu_rlen   (lsu_rlen),
    .lsu_burst  (lsu_burst),
    .lsu_rmask  (lsu_rmask),
    .lsu_rsign  (lsu_rsign),
    .lsu_rdata  (lsu_rdata),
    .lsu_wvalid (lsu_wvalid),
    .lsu_wready (lsu_wready),
    .lsu_waddr  (lsu_waddr),
    .lsu_wdata  (lsu_wdata),
    .lsu_wmask  (lsu_wmask),
    .lsu_err    (lsu_err),
    .bus        (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int          phase = 0;        // 0 none, 1 read, 2 write
  logic [31:0] exp_raddr;
  logic [7:0]  exp_rlen;
  logic        exp_rburst, exp_rsign;
  logic [1:0]  exp_rmask;
  logic [31:0] exp_waddr, exp_wdata;
  logic [1:0]  exp_wmask;
  logic        exp_err = 1'b0;
  int          rd_pulses, wr_pulses;
  logic [31:0] last_rdata, last_wdata;
  logic [3:0]  last_wstrb;
  logic [2:0]  last_arsize;
  logic [1:0]  last_arburst;
  logic [35:0] cmp_ew;
  bit          pw_en = 0;
  logic [31:0] pw_addr, pw_data;
  logic [1:0]  pw_mask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string what);
    checks++;
    errors++;
    $display("FAIL timeout_%s no response within cycle budget t=%0t", what, $time);
  endtask

  function automatic int bytes_of(input logic [1:0] m);
    return (m == 2'b00) ? 1 : (m == 2'b01) ? 2 : 4;
  endfunction

  // Expected read result: select the byte lanes starting at the offset.
  function automatic logic [31:0] exp_rd(input logic [31:0] raw, input int lo,
                                         input logic [1:0] m, input logic s);
    logic [7:0] by [4];
    logic [7:0] b0, b1;
    for (int i = 0; i < 4; i++) by[i] = raw[8*i +: 8];
    b0 = by[lo];
    b1 = (lo < 3) ? by[lo + 1] : 8'h00;
    if (m == 2'b00) return (s && b0[7]) ? {24'hFFFFFF, b0} : {24'h0, b0};
    if (m == 2'b01) return (s && b1[7]) ? {16'hFFFF, b1, b0} : {16'h0, b1, b0};
    return raw;
  endfunction

  // Expected {strobe, data} for a store: byte i carries source byte i-lo.
  function automatic logic [35:0] exp_wr(input logic [31:0] d, input int lo,
                                         input logic [1:0] m);
    logic [31:0] o;
    logic [3:0]  st;
    int nb;
    o = '0;
    st = '0;
    nb = bytes_of(m);
    for (int i = 0; i < 4; i++) begin
      if (i >= lo) begin
        o[8*i +: 8] = d[8*(i - lo) +: 8];
        if (i - lo < nb) st[i] = 1'b1;
      end
    end
    return {st, o};
  endfunction

  // Compare process
  always @(negedge clock) begin
    chk("lsu_err", 32'(lsu_err), 32'(exp_err));
    if (reset) exp_err = 1'b0;
    else if (ERR_EN && ((bus.rvalid && bus.rready && bus.rresp != 2'b00) ||
                        (bus.bvalid && bus.bready && bus.bresp != 2'b00)))
      exp_err = 1'b1;
    if (!reset) begin
      if (bus.arvalid) begin
        chk("ar_phase", 32'(phase), 32'd1);
        chk("araddr", bus.araddr, exp_raddr);
        chk("arlen", 32'(bus.arlen), 32'(exp_rlen));
        chk("arsize", 32'(bus.arsize), 32'(bytes_of(exp_rmask) == 1 ? 0 :
                                              bytes_of(exp_rmask) == 2 ? 1 : 2));
        chk("arburst", 32'(bus.arburst), exp_rburst ? 32'd1 : 32'd0);
        last_arsize  = bus.arsize;
        last_arburst = bus.arburst;
      end
      if (bus.awvalid) begin
        chk("aw_phase", 32'(phase), 32'd2);
        chk("awaddr", bus.awaddr, exp_waddr);
        chk("awsize", 32'(bus.awsize), 32'(bytes_of(exp_wmask) == 1 ? 0 :
                                              bytes_of(exp_wmask) == 2 ? 1 : 2));
        chk("awlen", 32'(bus.awlen), 32'd0);
        chk("awburst", 32'(bus.awburst), 32'd1);
      end
      if (bus.wvalid) begin
        cmp_ew = exp_wr(exp_wdata, int'(exp_waddr[1:0]), exp_wmask);
        chk("w_phase", 32'(phase), 32'd2);
        chk("wdata", bus.wdata, cmp_ew[31:0]);
        chk("wstrb", 32'(bus.wstrb), 32'(cmp_ew[35:32]));
        chk("wlast", 32'(bus.wlast), 32'd1);
        last_wdata = bus.wdata;
        last_wstrb = bus.wstrb;
      end
      if (lsu_rready) begin
        rd_pulses++;
        chk("rready_hs", 32'(bus.rvalid && bus.rready), 32'd1);
        chk("lsu_rdata", lsu_rdata,
            exp_rd(bus.rdata, int'(exp_raddr[1:0]), exp_rmask, exp_rsign));
        last_rdata = lsu_rdata;
      end
      if (lsu_wready) begin
        wr_pulses++;
        chk("wready_hs", 32'(bus.bvalid && bus.bready), 32'd1);
      end
    end
  end

  task automatic set_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
    lsu_wvalid = 1'b1; lsu_waddr = a; lsu_wdata = d; lsu_wmask = m;
    exp_waddr = a; exp_wdata = d; exp_wmask = m;
  endtask

  task automatic idle_checks();
    chk("idle_arvalid", 32'(bus.arvalid), 32'd0);
    chk("idle_rready", 32'(bus.rready), 32'd0);
    chk("idle_awvalid", 32'(bus.awvalid), 32'd0);
    chk("idle_wvalid", 32'(bus.wvalid), 32'd0);
    chk("idle_bready", 32'(bus.bready), 32'd0);
    chk("idle_lsu_rready", 32'(lsu_rready), 32'd0);
    chk("idle_lsu_wready", 32'(lsu_wready), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len, input logic burst,
                         input logic [1:0] m, input logic s, input bit fix,
                         input logic [31:0] fdata, input int bad_beat, input int abort_after);
    int n;
    @(posedge clock); #1;
    exp_raddr = a; exp_rlen = len; exp_rburst = burst; exp_rmask = m; exp_rsign = s;
    phase = 1; rd_pulses = 0;
    lsu_rvalid = 1'b1; lsu_raddr = a; lsu_rlen = len; lsu_burst = burst;
    lsu_rmask = m; lsu_rsign = s;
    if (pw_en) begin
      set_write(pw_addr, pw_data, pw_mask);
      pw_en = 0;
    end
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.arvalid && n < 20);
    if (!bus.arvalid) begin timeout("ar"); lsu_rvalid = 1'b0; return; end
    repeat ($urandom_range(0, 2)) @(negedge clock);
    @(posedge clock); #1 bus.arready = 1'b1;
    @(posedge clock); #1 bus.arready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == abort_after) begin
        reset = 1'b1; bus.rvalid = 1'b0; bus.rlast = 1'b0; lsu_rvalid = 1'b0;
        @(posedge clock); #1 reset = 1'b0; phase = 0;
        @(negedge clock);
        idle_checks();
        return;
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      bus.rvalid = 1'b1;
      bus.rdata  = fix ? fdata : $urandom;
      bus.rlast  = (b == int'(len));
      bus.rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
      n = 0;
      do begin @(negedge clock); n++; end while (!bus.rready && n < 20);
      if (!bus.rready) begin timeout("r"); bus.rvalid = 1'b0; lsu_rvalid = 1'b0; return; end
      @(posedge clock); #1;
      if (b == int'(len)) begin
        lsu_rvalid = 1'b0;
        phase = lsu_wvalid ? 2 : 0;
      end
      bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00;
    end
    @(negedge clock);
    chk("rd_pulses", 32'(rd_pulses), 32'(int'(len) + 1));
    chk("rd_done_rready", 32'(bus.rready), 32'd0);
    chk("rd_done_arvalid", 32'(bus.arvalid), 32'd0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m,
                          input logic [1:0] bresp, input bit preset, input int ad_in,
                          input int wd_in);
    int n, ad, wd, mx;
    if (!preset) begin
      @(posedge clock); #1;
      set_write(a, d, m);
    end
    phase = 2; wr_pulses = 0;
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.awvalid && n < 20);
    if (!bus.awvalid) begin timeout("aw"); lsu_wvalid = 1'b0; return; end
    ad = (ad_in < 0) ? int'($urandom_range(0, 3)) : ad_in;
    wd = (wd_in < 0) ? int'($urandom_range(0, 3)) : wd_in;
    mx = (ad > wd) ? ad : wd;
    for (int c = 0; c <= mx; c++) begin
      @(posedge clock); #1 bus.awready = (c == ad); bus.wready = (c == wd);
      @(negedge clock);
      chk("awvalid_hold", 32'(bus.awvalid), 32'(c <= ad));
      chk("wvalid_hold", 32'(bus.wvalid), 32'(c <= wd));
    end
    @(posedge clock); #1 bus.awready = 1'b0; bus.wready = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!bus.bready && n < 20);
    if (!bus.bready) begin timeout("b"); lsu_wvalid = 1'b0; return; end
    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    @(posedge clock); #1 bus.bvalid = 1'b1; bus.bresp = bresp;
    @(posedge clock); #1 bus.bvalid = 1'b0; bus.bresp = 2'b00; lsu_wvalid = 1'b0; phase = 0;
    @(negedge clock);
    chk("wr_pulses", 32'(wr_pulses), 32'd1);
    chk("wr_done_bready", 32'(bus.bready), 32'd0);
    chk("wr_done_awvalid", 32'(bus.awvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lsu_rvalid = 0; lsu_raddr = 0; lsu_rlen = 0; lsu_burst = 0; lsu_rmask = 0; lsu_rsign = 0;
    lsu_wvalid = 0; lsu_waddr = 0; lsu_wdata = 0; lsu_wmask = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    idle_checks();
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("rst_arlen", 32'(bus.arlen), 32'd0);

    // signed byte at the top lane
    do_read(32'h8000_0003, 8'd0, 1'b1, 2'b00, 1'b1, 1'b1, 32'h8012_3456, -1, -1);
    chk("lit_byte_rdata", last_rdata, 32'hFFFF_FF80);
    chk("lit_byte_arsize", 32'(last_arsize), 32'd0);

    // INCR burst of four words
    do_read(32'h0000_1000, 8'd3, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, -1, -1);
    chk("lit_burst_arburst", 32'(last_arburst), 32'd1);
    chk("lit_burst_beats", 32'(rd_pulses), 32'd4);

    // half store at offset 2
    do_write(32'h0000_0002, 32'h0000_1234, 2'b01, 2'b00, 1'b0, -1, -1);
    chk("lit_half_wdata", last_wdata, 32'h1234_0000);
    chk("lit_half_wstrb", 32'(last_wstrb), 32'b1100);

    // AW accepted two cycles before W
    do_write(32'h0000_0040, $urandom, 2'b10, 2'b00, 1'b0, 0, 2);

    // simultaneous read and write: read first, write follows
    pw_en = 1; pw_addr = 32'h0000_0085; pw_data = 32'hDEAD_BEEF; pw_mask = 2'b00;
    do_read(32'h0000_0102, 8'd1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, -1, -1);
    do_write(32'h0, 32'h0, 2'b00, 2'b00, 1'b1, -1, -1);
    chk("lit_prio_wstrb", 32'(last_wstrb), 32'b0010);

    // error response and stickiness
    do_write(32'h0000_0010, 32'hCAFE_F00D, 2'b10, 2'b10, 1'b0, -1, -1);
    chk("lit_err_set", 32'(lsu_err), 32'(ERR_EN));
    do_write(32'h0000_0014, 32'h0000_0001, 2'b10, 2'b00, 1'b0, -1, -1);
    chk("lit_err_held", 32'(lsu_err), 32'(ERR_EN));

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [7:0]  l;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        l = 8'($urandom_range(0, 4));
        do_read(a, l, 1'($urandom), 2'($urandom), 1'($urandom), 1'b0, 32'h0,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, int'(l))) : -1, -1);
      end else begin
        do_write(a, $urandom, 2'($urandom), ($urandom_range(0, 9) == 0) ? 2'b11 : 2'b00,
                 1'b0, -1, -1);
      end
    end

    // reset in the middle of a burst, then a normal FIXED read
    do_read(32'h0000_2000, 8'd5, 1'b1, 2'b10, 1'b0, 1'b0, 32'h0, -1, 2);
    chk("lit_err_after_reset", 32'(lsu_err), 32'd0);
    do_read(32'h0000_3006, 8'd1, 1'b0, 2'b01, 1'b1, 1'b1, 32'hF00F_0000, -1, -1);
    chk("lit_fixed_arburst", 32'(last_arburst), 32'd0);
    chk("lit_half_signed", last_rdata, 32'hFFFF_F00F);

    repeat (3) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_25040111_lsu.md
YSYX_25040111_LSU -- requirements
Module: ysyx_25040111_lsu

Interface
REQ-001 No parameters; widths fixed (32-bit address/data, 8-bit burst length).
REQ-002 clock  in  1  system clock.
REQ-003 reset  in  1  reset; synchronous, active-high.
REQ-004 lsu_rvalid / lsu_rready  in / out  1 / 1  read request; rready is a one-cycle pulse per returned beat.
REQ-005 lsu_raddr  in  32  read byte address.
REQ-006 lsu_rlen / lsu_burst  in  8 / 1  AXI arlen; INCR burst when 1, else FIXED.
REQ-007 lsu_rmask / lsu_rsign  in  2 / 1  size (00 byte, 01 half, 10/11 word); sign-extend when 1.
REQ-008 lsu_rdata  out  32  aligned, extended read beat; valid only while lsu_rready=1.
REQ-009 lsu_wvalid / lsu_wready  in / out  1 / 1  write request; wready is a one-cycle pulse on write completion.
REQ-010 lsu_waddr / lsu_wdata / lsu_wmask  in  32 / 32 / 2  write address, LSB-aligned data, size.
REQ-011 axi_arvalid / axi_arready / axi_araddr / axi_arlen / axi_arsize / axi_arburst  out/in/out/out/out/out  1/1/32/8/3/2  AXI4 AR channel.
REQ-012 axi_rvalid / axi_rready / axi_rdata / axi_rresp / axi_rlast  in/out/in/in/in  1/1/32/2/1  AXI4 R channel.
REQ-013 axi_awvalid / axi_awready / axi_awaddr / axi_awsize  out/in/out/out  1/1/32/3  AXI4 AW channel; awlen=0, awburst=INCR.
REQ-014 axi_wvalid / axi_wready / axi_wdata / axi_wstrb / axi_wlast  out/in/out/out/out  1/1/32/4/1  AXI4 W channel; wlast=1.
REQ-015 axi_bvalid / axi_bready / axi_bresp  in/out/in  1/1/2  AXI4 B channel.
REQ-016 lsu_err  out  1  sticky bus-error flag.

Function
REQ-017 FSM states: IDLE, AR, R, WR (AW+W), B; one transaction outstanding at a time.
REQ-018 IDLE: lsu_rvalid=1 latches addr/len/burst/mask/sign and enters AR next cycle; else lsu_wvalid=1 latches write fields and enters WR; read wins if both are high.
REQ-019 AR: axi_arvalid=1 with latched fields; arsize = mask==11 ? 2 : mask; on arready -> R.
REQ-020 R: axi_rready=1; each rvalid&rready beat pulses lsu_rready the same cycle (combinational pass-through); beat with rlast -> IDLE.
REQ-021 Read data: rdata >> (8*araddr[1:0]), then byte/half zero- or sign-extended per rsign; word passes unshifted.
REQ-022 WR: awvalid and wvalid asserted together, each dropped independently after its own handshake; both done -> B.
REQ-023 Write data: wdata << 8*addr[1:0]; wstrb = (0001/0011/1111 per mask) << addr[1:0], truncated to 4 bits.
REQ-024 B: bready=1; bvalid -> pulse lsu_wready for one cycle, -> IDLE.
REQ-025 Requests arriving outside IDLE are ignored until IDLE; requesters hold valid and fields stable until their ready pulse.
REQ-026 Misaligned half/word accesses are not split; the truncated strobe/shift is issued as-is.

Reset
REQ-027 Reset forces IDLE; every AXI valid/ready, lsu_rready, lsu_wready and lsu_err = 0; latched fields = 0. Reset mid-burst abandons the transaction with no drain.

Configuration
REQ-028 YSYX_25040111_LSU_ERR_EN defined: nonzero rresp on any beat or nonzero bresp sets lsu_err, which stays 1 until reset; undefined: responses ignored and lsu_err tied to 0.

Structure
REQ-029 FSM state encoding, size codes and AXI burst/resp constants belong in shared package ysyx_25040111_pkg.
REQ-030 Natural sub-module: ysyx_25040111_lsu_align (combinational shift/extend/strobe generation).

Verification
REQ-031 Read byte addr 0x80000003, rsign=1, axi_rdata=0x80xxxxxx -> arsize=0, lsu_rdata=0xFFFFFF80, one lsu_rready pulse.
REQ-032 Burst read arlen=3, INCR -> arburst=01, four lsu_rready pulses, IDLE after rlast.
REQ-033 Write half addr 0x02, wdata=0x1234 -> wstrb=1100, axi_wdata=0x12340000, lsu_wready pulses after bvalid.
REQ-034 awready 2 cycles before wready -> awvalid drops first, wvalid held; single B completion.
REQ-035 Reset asserted in R mid-burst -> all valids 0 next cycle; a new read issues normally.
REQ-036 With macro, bresp=2'b10 -> lsu_err=1 and held; without macro, lsu_err stays 0.
